// File: rtl/fcpu_pkg.sv
// Shared CPU definitions: opcode encoding, widths, and the memory-access
// result record with its store classifier.
package fcpu_pkg;

  localparam int INSTR_W  = 6;
  localparam int DATA_W   = 32;
  localparam int RSV_ID_W = 4;

  typedef enum logic [INSTR_W-1:0] {
    I_NOP     = 6'd0,
    I_LOAD    = 6'd1,
    I_LOADB   = 6'd2,
    I_STORE   = 6'd4,
    I_STOREB  = 6'd5,
    I_STORER  = 6'd6,
    I_STORET  = 6'd7,
    I_STORETB = 6'd8,
    I_OUTPUT  = 6'd9,
    I_ADD     = 6'd10
  } opcode_e;

  typedef struct packed {
    logic [RSV_ID_W-1:0] rob_id;
    logic [DATA_W-1:0]   data;
  } mau_result_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  function automatic logic is_store(input logic [INSTR_W-1:0] op);
    case (op)
      I_STORE, I_STOREB, I_STORER, I_STORET, I_STORETB: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fifo.sv
// Synchronous FIFO with 2**FIFO_DEPTH_W entries; head is visible on o_rdata
// whenever o_empty is low. Push and pop may occur in the same cycle.
module fifo #(
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH_W = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_empty,
  output logic              o_full
);

  localparam int DEPTH = 1 << FIFO_DEPTH_W;

  logic [DATA_W-1:0]       r_mem [DEPTH];
  logic [FIFO_DEPTH_W-1:0] r_wptr;
  logic [FIFO_DEPTH_W-1:0] r_rptr;
  logic [FIFO_DEPTH_W:0]   r_count;
  logic                    w_push;
  logic                    w_pop;

  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_rdata = r_mem[r_rptr];
  assign o_empty = (r_count == (FIFO_DEPTH_W+1)'(0));
  assign o_full  = (r_count == (FIFO_DEPTH_W+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + FIFO_DEPTH_W'(1);
      if (w_pop)  r_rptr <= r_rptr + FIFO_DEPTH_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (FIFO_DEPTH_W+1)'(1);
        2'b01:   r_count <= r_count - (FIFO_DEPTH_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/memory_access_unit.sv
// Executes in-order LOAD/STORE/OUTPUT requests against the data RAM and UART,
// returning load results on a private CDB port through a credit-guarded FIFO.
module memory_access_unit
  import fcpu_pkg::*;
#(
  parameter int MEM_ADDR_W   = 16,
  parameter int MEM_LATENCY  = 2,
  parameter int RESULT_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         i_valid,
  input  logic [INSTR_W-1:0]           i_opcode,
  input  logic [RSV_ID_W-1:0]          i_rsv_id,
  input  logic [DATA_W-1:0]            i_address,
  input  logic [DATA_W-1:0]            i_data,
  output logic                         i_ready,
  output logic [MEM_ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic                         mem_we,
  output logic                         mem_re,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic                         tx_valid,
  output logic [7:0]                   tx_data,
  input  logic                         tx_ready,
  input  logic                         rx_valid,
  input  logic [7:0]                   rx_data,
  output logic                         rx_ready,
  output logic [RSV_ID_W+DATA_W-1:0]   o_cdb,
  output logic                         o_cdb_valid,
  input  logic                         o_cdb_ready
);

  localparam int CDB_W        = RSV_ID_W + DATA_W;
  localparam int CRED_W       = $clog2(RESULT_DEPTH + 1);
  localparam int FIFO_DEPTH_W = $clog2(RESULT_DEPTH);

  logic                r_pipe_vld [MEM_LATENCY];
  logic [RSV_ID_W-1:0] r_pipe_rob [MEM_LATENCY];
  logic [CRED_W-1:0]   r_credits;
  tx_state_e           r_state;
  tx_state_e           w_next;
  logic [7:0]          r_tx_data;

  logic w_is_store, w_is_output, w_is_mmio, w_ready;
  logic w_st_acc, w_ld_acc, w_mmio_acc, w_out_acc;
  logic w_push, w_pop, w_empty, w_full;
  mau_result_t       w_push_data;
  logic [CDB_W-1:0]  w_head;

  assign w_is_store  = is_store(i_opcode);
  assign w_is_output = (i_opcode == I_OUTPUT);
  assign w_is_mmio   = !w_is_store && !w_is_output && (i_address == '1);

  // MMIO loads wait for an empty result path so they cannot overtake RAM loads.
  always_comb begin
    if (w_is_store)       w_ready = 1'b1;
    else if (w_is_output) w_ready = (r_state == TX_IDLE);
    else if (w_is_mmio)   w_ready = (r_credits == CRED_W'(0)) && rx_valid;
    else                  w_ready = (r_credits < CRED_W'(RESULT_DEPTH));
  end

  assign w_st_acc   = i_valid && w_ready && w_is_store;
  assign w_out_acc  = i_valid && w_ready && w_is_output;
  assign w_mmio_acc = i_valid && w_ready && w_is_mmio;
  assign w_ld_acc   = i_valid && w_ready && !w_is_store && !w_is_output && !w_is_mmio;

  assign i_ready   = w_ready;
  assign mem_we    = w_st_acc;
  assign mem_re    = w_ld_acc;
  assign mem_addr  = (w_st_acc || w_ld_acc) ? i_address[MEM_ADDR_W-1:0] : '0;
  assign mem_wdata = w_st_acc ? i_data : '0;
  assign rx_ready  = w_mmio_acc;

  always_ff @(posedge clk) begin
    for (int i = 0; i < MEM_LATENCY; i++) begin
      if (!nrst)       r_pipe_vld[i] <= 1'b0;
      else if (i == 0) r_pipe_vld[i] <= w_ld_acc;
      else             r_pipe_vld[i] <= r_pipe_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    r_pipe_rob[0] <= i_rsv_id;
    for (int i = 1; i < MEM_LATENCY; i++) r_pipe_rob[i] <= r_pipe_rob[i-1];
  end

  // Pipe exit and MMIO accept are exclusive: MMIO requires zero credits.
  always_comb begin
    if (r_pipe_vld[MEM_LATENCY-1]) begin
      w_push_data.rob_id = r_pipe_rob[MEM_LATENCY-1];
      w_push_data.data   = mem_rdata;
    end else begin
      w_push_data.rob_id = i_rsv_id;
      w_push_data.data   = {{(DATA_W-8){1'b0}}, rx_data};
    end
  end

  assign w_push = (r_pipe_vld[MEM_LATENCY-1] || w_mmio_acc) && !w_full;
  assign w_pop  = o_cdb_valid && o_cdb_ready;

  fifo #(
    .DATA_W      (CDB_W),
    .FIFO_DEPTH_W(FIFO_DEPTH_W)
  ) u_result_fifo (
    .clk    (clk),
    .nrst   (nrst),
    .i_push (w_push),
    .i_wdata(w_push_data),
    .i_pop  (w_pop),
    .o_rdata(w_head),
    .o_empty(w_empty),
    .o_full (w_full)
  );

  assign o_cdb       = w_head;
  assign o_cdb_valid = !w_empty;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_credits <= '0;
    end else begin
      case ({w_ld_acc || w_mmio_acc, w_pop})
        2'b10:   r_credits <= r_credits + CRED_W'(1);
        2'b01:   r_credits <= r_credits - CRED_W'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state   <= TX_IDLE;
      r_tx_data <= 8'h00;
    end else begin
      r_state <= w_next;
      if (w_out_acc) r_tx_data <= i_data[7:0];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      TX_IDLE: w_next = w_out_acc ? TX_SEND : TX_IDLE;
      TX_SEND: w_next = tx_ready ? TX_IDLE : TX_SEND;
      default: w_next = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_valid = (r_state == TX_SEND);
    tx_data  = r_tx_data;
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit with a 2-cycle synchronous RAM model,
// a CDB collector and handshake counters.
module tb_memory_access_unit;
  import fcpu_pkg::*;

  logic                clk = 1'b0;
  logic                nrst;
  logic                i_valid;
  logic [INSTR_W-1:0]  i_opcode;
  logic [RSV_ID_W-1:0] i_rsv_id;
  logic [DATA_W-1:0]   i_address;
  logic [DATA_W-1:0]   i_data;
  logic                i_ready;
  logic [15:0]         mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_we;
  logic                mem_re;
  logic [DATA_W-1:0]   mem_rdata;
  logic                tx_valid;
  logic [7:0]          tx_data;
  logic                tx_ready;
  logic                rx_valid;
  logic [7:0]          rx_data;
  logic                rx_ready;
  logic [35:0]         o_cdb;
  logic                o_cdb_valid;
  logic                o_cdb_ready;

  int total = 0;
  int bad   = 0;
  int base;
  int we_cnt = 0;
  int tx_cnt = 0;
  logic [35:0] got [$];
  logic [DATA_W-1:0] ram [256];
  logic [DATA_W-1:0] ram_s1;

  memory_access_unit dut (
    .clk(clk), .nrst(nrst), .i_valid(i_valid), .i_opcode(i_opcode),
    .i_rsv_id(i_rsv_id), .i_address(i_address), .i_data(i_data),
    .i_ready(i_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .o_cdb(o_cdb), .o_cdb_valid(o_cdb_valid), .o_cdb_ready(o_cdb_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    ram_s1    <= mem_re ? ram[mem_addr[7:0]] : 32'hDEADBEEF;
    mem_rdata <= ram_s1;
  end

  always @(posedge clk) begin
    if (mem_we) we_cnt <= we_cnt + 1;
    if (tx_valid && tx_ready) tx_cnt <= tx_cnt + 1;
    if (nrst && o_cdb_valid && o_cdb_ready) got.push_back(o_cdb);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [INSTR_W-1:0] op, input logic [3:0] rob,
                      input logic [31:0] addr, input logic [31:0] data);
    int n = 0;
    i_valid = 1'b1; i_opcode = op; i_rsv_id = rob; i_address = addr; i_data = data;
    #1;
    while (!i_ready && n < 40) begin
      step();
      n++;
    end
    chk("send_accept", 64'(n < 40), 64'd1);
    step();
    i_valid = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; i_valid = 1'b0; i_opcode = I_NOP; i_rsv_id = 4'd0;
    i_address = 32'd0; i_data = 32'd0; tx_ready = 1'b0; rx_valid = 1'b0;
    rx_data = 8'd0; o_cdb_ready = 1'b0;
    step(); step();
    chk("rst_cdb_valid", 64'(o_cdb_valid), 64'd0);
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_mem_re", 64'(mem_re), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_rx_ready", 64'(rx_ready), 64'd0);
    nrst = 1'b1; i_opcode = I_LOAD;
    #1;
    chk("rst_ready_load", 64'(i_ready), 64'd1);
    step();

    // Store then load same address: result exactly 3 cycles after accept.
    i_valid = 1'b1; i_opcode = I_STORE; i_address = 32'h10; i_data = 32'h1234;
    #1;
    chk("st_we", 64'(mem_we), 64'd1);
    chk("st_addr", 64'(mem_addr), 64'h10);
    chk("st_wdata", 64'(mem_wdata), 64'h1234);
    step();
    send(I_LOAD, 4'd3, 32'h10, 32'd0);
    chk("ld_lat_c1", 64'(o_cdb_valid), 64'd0);
    step();
    chk("ld_lat_c2", 64'(o_cdb_valid), 64'd0);
    step();
    chk("ld_lat_c3", 64'(o_cdb_valid), 64'd1);
    chk("ld_data", 64'(o_cdb), {28'd0, 4'd3, 32'h1234});
    o_cdb_ready = 1'b1;
    step();
    o_cdb_ready = 1'b0;
    chk("ld_popped", 64'(o_cdb_valid), 64'd0);
    chk("we_once", 64'(we_cnt), 64'd1);

    for (int i = 0; i < 6; i++) send(I_STORE, 4'd0, 32'h20 + 32'(i), 32'hA000 + 32'(i));

    // Six loads with the CDB stalled: four accepted, the rest wait.
    base = got.size();
    for (int i = 0; i < 4; i++) send(I_LOAD, 4'(4 + i), 32'h20 + 32'(i), 32'd0);
    i_valid = 1'b1; i_opcode = I_LOAD; i_rsv_id = 4'd8; i_address = 32'h24;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("full_stall", 64'(i_ready), 64'd0);
      step();
    end
    chk("full_head_valid", 64'(o_cdb_valid), 64'd1);
    chk("full_head", 64'(o_cdb), {28'd0, 4'd4, 32'hA000});
    o_cdb_ready = 1'b1;
    send(I_LOAD, 4'd8, 32'h24, 32'd0);
    send(I_LOAD, 4'd9, 32'h25, 32'd0);
    repeat (8) step();
    chk("full_count", 64'(got.size() - base), 64'd6);
    for (int i = 0; i < 6; i++)
      if (got.size() > base + i)
        chk("full_order", 64'(got[base + i]), 64'({4'(4 + i), 32'hA000 + 32'(i)}));

    // Pop coinciding with pipe push at full credits frees one slot.
    o_cdb_ready = 1'b0;
    base = got.size();
    for (int i = 0; i < 4; i++) send(I_LOAD, 4'(i), 32'h20 + 32'(i), 32'd0);
    o_cdb_ready = 1'b1;
    i_valid = 1'b1; i_opcode = I_LOAD; i_rsv_id = 4'd4; i_address = 32'h24;
    #1;
    chk("cred_full", 64'(i_ready), 64'd0);
    step();
    chk("cred_after_pop", 64'(i_ready), 64'd1);
    step();
    i_valid = 1'b0;
    repeat (8) step();
    chk("cred_count", 64'(got.size() - base), 64'd5);
    for (int i = 0; i < 5; i++)
      if (got.size() > base + i)
        chk("cred_order", 64'(got[base + i]), 64'({4'(i), 32'hA000 + 32'(i)}));

    // OUTPUT with tx_ready held low.
    o_cdb_ready = 1'b0;
    send(I_OUTPUT, 4'd0, 32'd0, 32'hFFFFFF41);
    i_valid = 1'b1; i_opcode = I_OUTPUT; i_data = 32'h42;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("tx_valid_hold", 64'(tx_valid), 64'd1);
      chk("tx_data_hold", 64'(tx_data), 64'h41);
      chk("tx_second_stall", 64'(i_ready), 64'd0);
      step();
    end
    i_valid = 1'b0; i_opcode = I_LOAD; i_address = 32'h20;
    #1;
    chk("tx_load_overlap", 64'(i_ready), 64'd1);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    chk("tx_idle", 64'(tx_valid), 64'd0);
    chk("tx_one_xfer", 64'(tx_cnt), 64'd1);

    // MMIO load behind two RAM loads.
    base = got.size();
    i_opcode = I_LOAD; i_address = 32'hFFFFFFFF;
    #1;
    chk("mmio_no_rx", 64'(i_ready), 64'd0);
    send(I_LOAD, 4'd1, 32'h20, 32'd0);
    send(I_LOAD, 4'd2, 32'h21, 32'd0);
    rx_valid = 1'b1; rx_data = 8'h7F;
    i_valid = 1'b1; i_opcode = I_LOAD; i_rsv_id = 4'd5; i_address = 32'hFFFFFFFF;
    #1;
    chk("mmio_wait", 64'(i_ready), 64'd0);
    chk("mmio_rx_ready", 64'(rx_ready), 64'd0);
    o_cdb_ready = 1'b1;
    send(I_LOAD, 4'd5, 32'hFFFFFFFF, 32'd0);
    rx_valid = 1'b0;
    chk("mmio_lat", 64'(o_cdb_valid), 64'd1);
    chk("mmio_data", 64'(o_cdb), {28'd0, 4'd5, 32'h7F});
    repeat (4) step();
    chk("mmio_count", 64'(got.size() - base), 64'd3);
    if (got.size() >= base + 3) begin
      chk("mmio_r0", 64'(got[base]), {28'd0, 4'd1, 32'hA000});
      chk("mmio_r1", 64'(got[base + 1]), {28'd0, 4'd2, 32'hA001});
      chk("mmio_r2", 64'(got[base + 2]), {28'd0, 4'd5, 32'h7F});
    end

    // Reset with loads in flight and FIFO occupied.
    o_cdb_ready = 1'b0;
    base = got.size();
    for (int i = 0; i < 4; i++) send(I_LOAD, 4'(i), 32'h20 + 32'(i), 32'd0);
    nrst = 1'b0;
    step();
    nrst = 1'b1; i_opcode = I_LOAD; i_address = 32'h20;
    #1;
    chk("mrst_cdb_valid", 64'(o_cdb_valid), 64'd0);
    chk("mrst_ready", 64'(i_ready), 64'd1);
    o_cdb_ready = 1'b1;
    repeat (6) step();
    chk("mrst_no_stale", 64'(got.size() - base), 64'd0);
    chk("mrst_cdb_idle", 64'(o_cdb_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
